// File: rtl/pe_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : pe_add_arb
// Description : Round-robin arbiter and sequencer that shares one external
//               combinational 64-bit adder between NREQ requesters. Operand
//               beats arrive over per-requester valid/ready handshakes. The
//               winner's operands are driven to the adder. The sum, carry-out,
//               requester ID and last-beat flag are then captured into a
//               single-entry response register, which honours backpressure.
//               A requester can chain beats to build a multi-word add. The
//               grant stays locked to that requester for the whole chain, and
//               the carry is passed from one beat to the next internally.
// Ports       :
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   req_valid/req_ready [NREQ]  per-requester beat handshake (one-hot ready)
//   req_a/req_b [NREQ*WIDTH]    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin [NREQ]              carry-in, used only on the first beat of a chain
//   req_chain [NREQ]            1 = more beats follow in this chain
//   add_a/add_b/add_cin         operands driven to the shared adder
//   add_sum/add_cout            combinational result returned by the adder
//   rsp_valid/rsp_ready         response register handshake
//   rsp_id/rsp_sum/rsp_cout     registered requester ID, sum and carry-out
//   rsp_last                    1 = final beat of a chain (or an unchained add)
// Revision    : 1.0 - initial release
// ============================================================================
module pe_add_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   input  logic [NREQ-1:0]       req_chain,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_cin,
   input  logic [WIDTH-1:0]      add_sum,
   input  logic                  add_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_last
);

   // -------------------------------------------------------------------------
   // Arbiter states
   // -------------------------------------------------------------------------
   localparam logic [0:0] ST_IDLE   = 1'b0;  // no chain owner, round-robin open
   localparam logic [0:0] ST_LOCKED = 1'b1;  // chain in progress, owner fixed

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   logic [0:0]       state_q,     state_d;
   logic [IDW-1:0]   lock_id_q,   lock_id_d;
   logic             carry_q,     carry_d;
   logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
   logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
   logic             rsp_cout_q,  rsp_cout_d;
   logic             rsp_last_q,  rsp_last_d;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   logic             slot_free;
   logic             rr_found;
   logic [IDW-1:0]   rr_idx;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_id;
   logic [IDW-1:0]   sel_id;
   logic             gnt_chain;

   logic [WIDTH-1:0] a_arr [NREQ];
   logic [WIDTH-1:0] b_arr [NREQ];

   // -------------------------------------------------------------------------
   // Returns (base + offs) mod NREQ. The caller guarantees base < NREQ and
   // offs < NREQ, so the sum is below 2*NREQ and one conditional subtract
   // is enough. One extra bit of width keeps that sum from overflowing.
   // -------------------------------------------------------------------------
   function automatic logic [IDW-1:0] idx_wrap(input logic [IDW-1:0] base,
                                               input logic [IDW:0]   offs);
      logic [IDW:0] s;
      s = {1'b0, base} + offs;
      if (s >= (IDW+1)'(NREQ)) begin
         s = s - (IDW+1)'(NREQ);
      end
      return s[IDW-1:0];
   endfunction

   // -------------------------------------------------------------------------
   // Unpack the flat operand buses so each requester can be indexed by ID
   // -------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_unpack
         assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
         assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
      end
   endgenerate

   // The response register can take a new beat when it is empty or is being
   // drained in this same cycle.
   assign slot_free = ~rsp_valid_q | rsp_ready;

   // -------------------------------------------------------------------------
   // Round-robin search: find the first valid requester at or after rr_ptr
   // -------------------------------------------------------------------------
   always_comb begin
      logic [IDW-1:0] cand;
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = idx_wrap(rr_ptr_q, (IDW+1)'(k));
         if (!rr_found && req_valid[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Grant selection. While locked, only the chain owner can be granted, so
   // no other requester can slip in between the beats of a multi-word add.
   // -------------------------------------------------------------------------
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = rr_idx;
      if (rst_n && slot_free) begin
         if (state_q == ST_LOCKED) begin
            gnt_id  = lock_id_q;
            gnt_vld = req_valid[lock_id_q];
         end else begin
            gnt_id  = rr_idx;
            gnt_vld = rr_found;
         end
      end
   end

   // req_ready is one-hot at most and depends only on the handshake and
   // arbitration state, never on the operand data.
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_ready
         assign req_ready[i] = gnt_vld && (gnt_id == IDW'(i));
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Adder operand mux. When nothing is granted, the adder inputs are don't
   // care. The mux still follows a stable choice (the lock owner, or else
   // rr_ptr) so that the inputs do not toggle for no reason.
   // -------------------------------------------------------------------------
   always_comb begin
      if (gnt_vld) begin
         sel_id = gnt_id;
      end else if (state_q == ST_LOCKED) begin
         sel_id = lock_id_q;
      end else begin
         sel_id = rr_ptr_q;
      end
   end

   assign add_a     = a_arr[sel_id];
   assign add_b     = b_arr[sel_id];
   // Later beats of a chain take the carry stored from the previous beat.
   // The requester's own carry-in is only honoured on the first beat.
   assign add_cin   = (state_q == ST_LOCKED) ? carry_q : req_cin[sel_id];
   assign gnt_chain = req_chain[gnt_id];

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      lock_id_d   = lock_id_q;
      carry_d     = carry_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_last_d  = rsp_last_q;

      // Drain first. An accepted beat below may refill the slot in the same
      // cycle.
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      if (gnt_vld) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_id;
         rsp_sum_d   = add_sum;
         rsp_cout_d  = add_cout;
         rsp_last_d  = ~gnt_chain;

         if (gnt_chain) begin
            state_d   = ST_LOCKED;
            lock_id_d = gnt_id;
            carry_d   = add_cout;
         end else begin
            // The pointer moves only when a chain completes. Fairness is
            // therefore counted per transaction, not per beat.
            state_d  = ST_IDLE;
            rr_ptr_d = idx_wrap(gnt_id, (IDW+1)'(1));
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lock_id_q   <= '0;
         carry_q     <= 1'b0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_id_q   <= lock_id_d;
         carry_q     <= carry_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_last  = rsp_last_q;

endmodule
`default_nettype wire
